vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing source for the display path; the producer of the h_cnt/v_cnt/frame interface
//  that every sprite and molecule block consumes. Divides the system clock to a pixel-rate
//  enable and runs horizontal/vertical counters. Decodes hsync, vsync and video_on, and emits
//  a one-clock frame pulse at the start of vertical blanking so movement logic updates off-screen.
// PARAMETERS
//  CLK_DIV   4    system clocks per pixel (100 MHz -> 25 MHz)
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, in pixels
//  H_SYNC    96   hsync width, in pixels
//  H_BP      48   horizontal back porch, in pixels (H_TOTAL = 800)
//  V_ACTIVE  480  visible lines
//  V_FP      10   vertical front porch, in lines
//  V_SYNC    2    vsync width, in lines
//  V_BP      33   vertical back porch, in lines (V_TOTAL = 525)
// PORTS
//  clk         in   1   system clock
//  reset       in   1   asynchronous, active-high reset
//  pixel_tick  out  1   one-clk enable, once every CLK_DIV clks
//  h_cnt       out  10  horizontal pixel index, 0..H_TOTAL-1
//  v_cnt       out  10  vertical line index, 0..V_TOTAL-1
//  hsync       out  1   horizontal sync, active low
//  vsync       out  1   vertical sync, active low
//  video_on    out  1   high when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE
//  frame       out  1   one-clk pulse on entry to (h=0, v=V_ACTIVE)
// BEHAVIOUR
//  - Clock/reset: one clock, clk. reset is asynchronous and active-high.
//  - Reset values: divider=0, h_cnt=0, v_cnt=0, frame=0, pixel_tick=0, hsync=1, vsync=1, video_on=1.
//  - Divider: counts 0..CLK_DIV-1. pixel_tick=1 combinationally while divider==CLK_DIV-1.
//    After reset release the first tick occurs on the 4th clk edge window (divider=3).
//  - Counter advance: h_cnt and v_cnt change only on a clk edge where pixel_tick=1.
//    - h_cnt==H_TOTAL-1 -> h_cnt=0 and v_cnt increments. Otherwise h_cnt increments.
//    - v_cnt==V_TOTAL-1 at an h wrap -> v_cnt=0.
//    - No other state is reachable; counters never exceed their TOTAL-1.
//  - Sync decode (combinational from h_cnt/v_cnt, zero latency):
//    - hsync=0 for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
//    - vsync=0 for v_cnt in [490,491].
//  - frame: registered. It is set on the same edge that moves the counters from
//    (H_TOTAL-1, V_ACTIVE-1) to (0, V_ACTIVE), and cleared on the next clk.
//    Exactly 1 clk wide; one pulse per 800*525*CLK_DIV = 1,680,000 clks.
//  - Widths: all compares use 10-bit unsigned. TOTAL values must be <= 1024 (parameter constraint).
//  - Reset mid-frame: counters, divider and frame return to reset values immediately (async).
//    An in-flight frame pulse is cut short.
// CONFIGURATION
//  - Macro VGA_SYNC_DELAY_EN.
//  - Defined: hsync, vsync and video_on become registers loaded on pixel_tick from the current
//    counts. They lag h_cnt/v_cnt by one pixel (CLK_DIV clks), to align with a registered RGB stage.
//    Reset values are hsync=1, vsync=1, video_on=0.
//  - Undefined: the combinational decode above. h_cnt, v_cnt, frame and pixel_tick are unaffected.
// STRUCTURE
//  - Package vga_pkg: H_ACTIVE/H_FP/H_SYNC/H_BP and V_* defaults, plus derived constants
//    H_TOTAL, V_TOTAL, H_SYNC_START/END and V_SYNC_START/END.
//  - Sub-module pixel_tick_gen(clk, reset, tick) #(CLK_DIV): the divider.
//  - Counters, decode and frame logic live in the top.
// TESTING
//  1. Reset release, then run 8 clks -> pixel_tick high on clks 4 and 8. h_cnt 0->1->2. v_cnt=0. frame=0.
//  2. Force to h_cnt=799, v_cnt=10, then one tick -> h_cnt=0, v_cnt=11. hsync=1, video_on=1.
//  3. Sweep one line -> video_on falls at h=640. hsync low for exactly 96 ticks (h=656..751).
//  4. Run 2 frames -> frame pulses exactly twice, each 1 clk wide, at (0,480), 1,680,000 clks apart.
//     vsync low only for v=490..491. Wrap (799,524) -> (0,0).
//  5. Assert reset at h=300, v=200 between clk edges -> h_cnt=0, v_cnt=0, frame=0 with no clk edge.
//  6. With VGA_SYNC_DELAY_EN -> hsync falls on the tick after h_cnt reaches 656.
//     video_on=0 throughout reset.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480 raster geometry, derived sync windows and a window-compare helper
package vga_pkg;
   localparam int CLK_DIV = 4;
   localparam int H_ACTIVE = 640;
   localparam int H_FP = 16;
   localparam int H_SYNC = 96;
   localparam int H_BP = 48;
   localparam int V_ACTIVE = 480;
   localparam int V_FP = 10;
   localparam int V_SYNC = 2;
   localparam int V_BP = 33;
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int H_SYNC_END = H_SYNC_START + H_SYNC - 1;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam int V_SYNC_END = V_SYNC_START + V_SYNC - 1;
   function automatic logic in_window(logic [9:0] x, int lo, int hi);
      return x >= 10'(lo) && x <= 10'(hi);
   endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle from the timing generator to sprite/molecule consumers
interface vga_timing_gen_if;
   logic pixel_tick;
   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic hsync;
   logic vsync;
   logic video_on;
   logic frame;
   modport master (output pixel_tick, h_cnt, v_cnt, hsync, vsync, video_on, frame);
   modport slave (input pixel_tick, h_cnt, v_cnt, hsync, vsync, video_on, frame);
endinterface

// File: rtl/pixel_tick_gen.sv
// pixel_tick_gen: divides clk by CLK_DIV into a one-clock pixel enable
module pixel_tick_gen #(
   parameter int CLK_DIV = 4
) (
   input logic clk,
   input logic reset,
   output logic tick
);
   localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   logic [W-1:0] div;
   assign tick = div == W'(CLK_DIV - 1);
   always_ff @(posedge clk or posedge reset)
      if (reset) div <= '0;
      else div <= tick ? '0 : div + W'(1);
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-rate raster counters, sync/video decode and a frame pulse at vblank entry.
// Defining VGA_SYNC_DELAY_EN registers hsync/vsync/video_on one pixel behind the counts.
module vga_timing_gen #(
   parameter int CLK_DIV = vga_pkg::CLK_DIV,
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int H_FP = vga_pkg::H_FP,
   parameter int H_SYNC = vga_pkg::H_SYNC,
   parameter int H_BP = vga_pkg::H_BP,
   parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int V_FP = vga_pkg::V_FP,
   parameter int V_SYNC = vga_pkg::V_SYNC,
   parameter int V_BP = vga_pkg::V_BP
) (
   input logic clk,
   input logic reset,
   vga_timing_gen_if.master vga
);
   import vga_pkg::*;
   localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] V_PRE_BLANK = 10'(V_ACTIVE - 1);
   logic tick;
   logic [9:0] h;
   logic [9:0] v;
   logic fr;
   logic hs_d, vs_d, von_d;
   logic hs, vs, von;
   pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_div (
      .clk(clk),
      .reset(reset),
      .tick(tick)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         h <= '0;
         v <= '0;
         fr <= 1'b0;
      end else begin
         fr <= tick && h == H_LAST && v == V_PRE_BLANK;
         if (tick) begin
            h <= h == H_LAST ? '0 : h + 10'd1;
            if (h == H_LAST) v <= v == V_LAST ? '0 : v + 10'd1;
         end
      end
   assign hs_d = !in_window(h, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC - 1);
   assign vs_d = !in_window(v, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC - 1);
   assign von_d = h < 10'(H_ACTIVE) && v < 10'(V_ACTIVE);
`ifdef VGA_SYNC_DELAY_EN
   // Lags the counts by one pixel to line up with a registered RGB stage
   always_ff @(posedge clk or posedge reset)
      if (reset) {hs, vs, von} <= 3'b110;
      else if (tick) {hs, vs, von} <= {hs_d, vs_d, von_d};
`else
   assign {hs, vs, von} = {hs_d, vs_d, von_d};
`endif
   assign vga.pixel_tick = tick;
   assign vga.h_cnt = h;
   assign vga.v_cnt = v;
   assign vga.hsync = hs;
   assign vga.vsync = vs;
   assign vga.video_on = von;
   assign vga.frame = fr;
endmodule
